// File: rtl/sys_wr_pkg.sv
// Shared types and size helpers for the system-bus stream writer.
package sys_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } wr_state_t;

    function automatic int bytes_per_beat(input int dw);
        return dw / 8;
    endfunction

    function automatic int burst_bytes(input int burst, input int dw);
        return burst * (dw / 8);
    endfunction

endpackage

// File: rtl/sys_wr_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; level is the pointer difference.
module sys_wr_fifo #(
    parameter int DW = 64,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = level[AW];
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/axi_sys_stream_writer.sv
// Streams in_data into a circular buffer on the system bus in fixed-length bursts.
// Optional SYS_WR_BURST_CNT_EN adds a completed-burst counter output.
module axi_sys_stream_writer
    import sys_wr_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int LW      = 4,
    parameter int BURST   = 8,
    parameter int FIFO_AW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   cfg_start,
    input  logic [AW-1:0]   cfg_end,
    input  logic            ctrl_start,
    input  logic            ctrl_stop,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    output logic [AW-1:0]   waddr,
    output logic [DW-1:0]   wdata,
    output logic [DW/8-1:0] wsel,
    output logic [2:0]      wsize,
    output logic            wvalid,
    output logic [LW-1:0]   wlen,
    output logic            wfixed,
    input  logic            wrdy,
    input  logic            werr,
    output logic            busy,
    output logic [AW-1:0]   wr_addr,
    output logic            wrapped,
    output logic            overflow,
`ifdef SYS_WR_BURST_CNT_EN
    output logic [31:0]     burst_cnt,
`endif
    output logic            bus_err
);
    localparam logic [AW:0]      BB_INC    = (AW+1)'(burst_bytes(BURST, DW));
    localparam logic [LW:0]      LAST_BEAT = (LW+1)'(BURST - 1);
    localparam logic [FIFO_AW:0] BURST_LVL = (FIFO_AW+1)'(BURST);

    wr_state_t       state_q, state_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d, waddr_q, waddr_d;
    logic [LW:0]     beat_q, beat_d;
    logic            wvalid_q, wvalid_d, stop_pend_q, stop_pend_d;
    logic            wrapped_q, wrapped_d, overflow_q, overflow_d, bus_err_q, bus_err_d;
    logic [AW:0]     next_addr;
    logic            armed, start_go, beat_fire, last_beat;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FIFO_AW:0] fifo_level;
    logic [DW-1:0]   fifo_head;

    assign armed     = (state_q != ST_IDLE);
    assign start_go  = (state_q == ST_IDLE) && ctrl_start && !ctrl_stop;
    assign beat_fire = wvalid_q & wrdy;
    assign last_beat = beat_fire && (beat_q == LAST_BEAT);
    assign fifo_push = armed & in_valid & ~fifo_full;
    assign fifo_pop  = beat_fire & ~fifo_empty;
    assign next_addr = {1'b0, wr_addr_q} + BB_INC;

    sys_wr_fifo #(.DW(DW), .AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start_go),
        .push  (fifo_push),
        .din   (in_data),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        waddr_d     = waddr_q;
        beat_d      = beat_q;
        wvalid_d    = wvalid_q;
        stop_pend_d = stop_pend_q;
        wrapped_d   = wrapped_q;
        overflow_d  = overflow_q | (armed & in_valid & fifo_full);
        bus_err_d   = bus_err_q | (beat_fire & werr);
        case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    state_d     = ST_WAIT;
                    wr_addr_d   = cfg_start;
                    stop_pend_d = 1'b0;
                end
            end
            ST_WAIT: begin
                // A stop here wins over a ready burst: nothing is in flight yet.
                if (ctrl_stop) begin
                    state_d = ST_IDLE;
                end else if (fifo_level >= BURST_LVL) begin
                    state_d  = ST_BURST;
                    wvalid_d = 1'b1;
                    waddr_d  = wr_addr_q;
                    beat_d   = '0;
                end
            end
            ST_BURST: begin
                if (ctrl_stop) stop_pend_d = 1'b1;
                if (beat_fire) beat_d = beat_q + (LW+1)'(1);
                if (last_beat) begin
                    wvalid_d    = 1'b0;
                    stop_pend_d = 1'b0;
                    state_d     = (stop_pend_q || ctrl_stop) ? ST_IDLE : ST_WAIT;
                    if (next_addr > {1'b0, cfg_end}) begin
                        wr_addr_d = cfg_start;
                        wrapped_d = 1'b1;
                    end else begin
                        wr_addr_d = next_addr[AW-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_addr_q   <= '0;
            waddr_q     <= '0;
            beat_q      <= '0;
            wvalid_q    <= 1'b0;
            stop_pend_q <= 1'b0;
            wrapped_q   <= 1'b0;
            overflow_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            waddr_q     <= waddr_d;
            beat_q      <= beat_d;
            wvalid_q    <= wvalid_d;
            stop_pend_q <= stop_pend_d;
            wrapped_q   <= wrapped_d;
            overflow_q  <= overflow_d;
            bus_err_q   <= bus_err_d;
        end
    end

`ifdef SYS_WR_BURST_CNT_EN
    logic [31:0] burst_cnt_q, burst_cnt_d;

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (start_go)       burst_cnt_d = '0;
        else if (last_beat) burst_cnt_d = burst_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) burst_cnt_q <= '0;
        else     burst_cnt_q <= burst_cnt_d;
    end

    assign burst_cnt = burst_cnt_q;
`endif

    // Head is masked outside a burst so wdata reads zero in reset and idle.
    assign wdata    = wvalid_q ? fifo_head : '0;
    assign waddr    = waddr_q;
    assign wvalid   = wvalid_q;
    assign wsel     = '1;
    assign wsize    = 3'($clog2(bytes_per_beat(DW)));
    assign wlen     = LW'(BURST - 1);
    assign wfixed   = 1'b0;
    assign busy     = armed;
    assign wr_addr  = wr_addr_q;
    assign wrapped  = wrapped_q;
    assign overflow = overflow_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_axi_sys_stream_writer.sv
// Directed bench for axi_sys_stream_writer with a transaction-level reference model.
module tb_axi_sys_stream_writer;
    localparam int BURST = 8;
    localparam int DEPTH = 16;
    localparam int BB    = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_start = 32'h1000_0000, cfg_end = 32'h1000_00C0;
    logic        ctrl_start = 1'b0, ctrl_stop = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [31:0] waddr, wr_addr;
    logic [63:0] wdata;
    logic [7:0]  wsel;
    logic [2:0]  wsize;
    logic [3:0]  wlen;
    logic        wvalid, wfixed, busy, wrapped, overflow, bus_err;
    logic        wrdy = 1'b1, werr = 1'b0;

    axi_sys_stream_writer dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_end(cfg_end),
        .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .in_data(in_data), .in_valid(in_valid),
        .waddr(waddr), .wdata(wdata), .wsel(wsel), .wsize(wsize), .wvalid(wvalid),
        .wlen(wlen), .wfixed(wfixed), .wrdy(wrdy), .werr(werr), .busy(busy),
        .wr_addr(wr_addr), .wrapped(wrapped), .overflow(overflow), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the bus must show, derived from stream/queue bookkeeping.
    logic [63:0] exp_q[$];
    logic [31:0] burst_log[$];
    logic [31:0] base = '0, exp_wr_addr = '0;
    int          occ = 0, beat_idx = 0, done = 0, nb = 1, scen_beats = 0;
    bit          armed = 0, stop_pend = 0, exp_wv = 0;
    bit          exp_wrapped = 0, exp_ovf = 0, exp_berr = 0;

    always @(negedge clk) begin
        bit was_armed, nxt_wv;
        if (rst) begin
            armed = 0; stop_pend = 0; occ = 0; beat_idx = 0; done = 0;
            exp_q.delete(); exp_wr_addr = '0; exp_wv = 0;
            exp_wrapped = 0; exp_ovf = 0; exp_berr = 0;
            chk("rst_wvalid", wvalid, 0);
            chk("rst_wdata", wdata, 0);
            chk("rst_busy", busy, 0);
            chk("rst_status", {wrapped, overflow, bus_err}, 0);
            chk("rst_addr", {waddr, wr_addr}, 0);
        end else begin
            chk("wvalid", wvalid, exp_wv);
            chk("busy", busy, armed);
            chk("wr_addr", wr_addr, exp_wr_addr);
            chk("wrapped", wrapped, exp_wrapped);
            chk("overflow", overflow, exp_ovf);
            chk("bus_err", bus_err, exp_berr);
            if (wvalid) begin
                chk("consts", {wlen, wsize, wsel, wfixed}, {4'd7, 3'd3, 8'hFF, 1'b0});
                chk("waddr", waddr, base + 32'((done % nb) * BB));
                chk("head_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("wdata", wdata, exp_q[0]);
            end
            was_armed = armed;
            if (wvalid) nxt_wv = !(wrdy && beat_idx == BURST - 1);
            else        nxt_wv = armed && !ctrl_stop && occ >= BURST;
            if (armed && in_valid) begin
                if (occ < DEPTH) begin exp_q.push_back(in_data); occ++; end
                else exp_ovf = 1;
            end
            if (wvalid) begin
                if (ctrl_stop) stop_pend = 1;
                if (wrdy) begin
                    if (beat_idx == 0) burst_log.push_back(waddr);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    occ--; scen_beats++; beat_idx++;
                    if (werr) exp_berr = 1;
                    if (beat_idx == BURST) begin
                        beat_idx = 0; done++;
                        exp_wr_addr = base + 32'((done % nb) * BB);
                        if (done % nb == 0) exp_wrapped = 1;
                        if (stop_pend) armed = 0;
                        stop_pend = 0;
                    end
                end
            end else if (ctrl_stop) begin
                armed = 0;
            end
            if (!was_armed && ctrl_start && !ctrl_stop) begin
                armed = 1; occ = 0; exp_q.delete(); beat_idx = 0; done = 0;
                base = cfg_start; exp_wr_addr = cfg_start;
                nb = int'((cfg_end - cfg_start) / BB) + 1;
            end
            exp_wv = nxt_wv;
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask

    task automatic pulse(input bit st, input bit sp);
        tick(); ctrl_start = st; ctrl_stop = sp;
        tick(); ctrl_start = 0; ctrl_stop = 0;
    endtask

    task automatic send(input int n, input logic [63:0] seed);
        for (int i = 0; i < n; i++) begin
            tick(); in_valid = 1; in_data = seed + 64'(i);
        end
        tick(); in_valid = 0; in_data = '0;
    endtask

    task automatic wait_beats(input int n, input string name);
        int i = 0;
        while (scen_beats < n && i < 300) begin @(negedge clk); i++; end
        chk(name, 64'(scen_beats), 64'(n));
    endtask

    task automatic stop_idle(input string name);
        int i = 0;
        pulse(0, 1);
        while (busy && i < 100) begin tick(); i++; end
        chk(name, busy, 0);
    endtask

    task automatic new_scen(); scen_beats = 0; burst_log.delete(); endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        rst = 0;
        tick();
        chk("idle_busy", busy, 0);

        // start and stop together: stop wins
        pulse(1, 1);
        tick();
        chk("start_stop_idle", busy, 0);

        // single burst
        new_scen();
        pulse(1, 0);
        send(8, 64'hA000_0000_0000_0000);
        wait_beats(8, "s1_beats");
        repeat (2) tick();
        chk("s1_addr", burst_log.size() > 0 ? burst_log[0] : 32'hX, 32'h1000_0000);
        chk("s1_wr_addr", wr_addr, 32'h1000_0040);
        stop_idle("s1_stop");

        // wrap around the buffer, with a start pulse that must be ignored
        new_scen();
        pulse(1, 0);
        fork
            send(40, 64'hB000_0000_0000_0000);
            begin repeat (12) tick(); pulse(1, 0); end
        join
        wait_beats(40, "s2_beats");
        repeat (2) tick();
        chk("s2_bursts", 64'(burst_log.size()), 5);
        if (burst_log.size() == 5) begin
            chk("s2_b1", burst_log[1], 32'h1000_0040);
            chk("s2_b3", burst_log[3], 32'h1000_00C0);
            chk("s2_b4", burst_log[4], 32'h1000_0000);
        end
        chk("s2_wrapped", wrapped, 1);
        stop_idle("s2_stop");

        // stalled bus: 17 words into a 16-deep FIFO
        new_scen();
        wrdy = 0;
        pulse(1, 0);
        send(17, 64'hC000_0000_0000_0000);
        repeat (2) tick();
        wrdy = 1;
        wait_beats(16, "s3_beats");
        repeat (10) tick();
        chk("s3_exact16", 64'(scen_beats), 16);
        chk("s3_overflow", overflow, 1);
        stop_idle("s3_stop");

        // stop mid-burst completes the burst
        new_scen();
        pulse(1, 0);
        send(8, 64'hD000_0000_0000_0000);
        wait_beats(3, "s4_beat3");
        pulse(0, 1);
        wait_beats(8, "s4_beats");
        tick();
        chk("s4_idle", busy, 0);

        // bus error on one beat is sticky
        new_scen();
        pulse(1, 0);
        send(8, 64'hE000_0000_0000_0000);
        wait_beats(2, "s5_beat2");
        tick(); werr = 1;
        tick(); werr = 0;
        wait_beats(8, "s5_beats");
        repeat (2) tick();
        chk("s5_bus_err", bus_err, 1);
        stop_idle("s5_stop");
        pulse(1, 0);
        chk("s5_sticky", bus_err, 1);
        stop_idle("s5_stop2");

        // reset mid-burst
        new_scen();
        pulse(1, 0);
        send(8, 64'hF000_0000_0000_0000);
        wait_beats(5, "s6_beat5");
        @(posedge clk); #2;
        chk("s6_pre_rst_wvalid", wvalid, 1);
        rst = 1; #1;
        chk("s6_async_wvalid", wvalid, 0);
        repeat (2) tick();
        rst = 0;
        @(negedge clk);
        chk("s6_after", {busy, wvalid, wrapped, overflow, bus_err}, 0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
